// File: rtl/i2s_rx_deserializer.sv
`timescale 1ns/1ps
// I2S receive deserializer: oversamples BCLK/LRCLK/SDATA in the clk domain, assembles
// one stereo frame and presents it with a single-cycle sample_valid pulse.
module i2s_rx_deserializer #(
   parameter int DATA_WIDTH = 24,
   parameter int SLOT_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  bclk_i,
   input  logic                  lrclk_i,
   input  logic                  sdata_i,
   input  logic                  err_clear,
   output logic [DATA_WIDTH-1:0] left_data,
   output logic [DATA_WIDTH-1:0] right_data,
   output logic                  sample_valid,
   output logic                  frame_err
);

   localparam int CW = $clog2(SLOT_WIDTH + 1);

   typedef enum logic [1:0] {
      SYNC  = 2'd0,
      LEFT  = 2'd1,
      RIGHT = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [1:0]            bclk_sync, lrclk_sync, sdata_sync;
   logic                  bclk_d;
   logic                  rise_evt;
   logic                  lr_smp, sd_smp;
   logic                  lr_prev;
   logic [CW-1:0]         bit_cnt;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] left_hold;

   logic                  boundary;
   logic                  full_slot;
   logic                  overrun;
   logic                  load_left;
   logic                  load_pair;
   logic                  err_set;

   // Two-flop synchronizers; all three lines share the same depth so their
   // relative timing from the codec is preserved.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bclk_sync  <= '0;
         lrclk_sync <= '0;
         sdata_sync <= '0;
      end else begin
         // NOTE: non-blocking assignments make each stage sample the previous
         // stage's old value, which is what builds a real flop chain.
         bclk_sync  <= {bclk_sync[0],  bclk_i};
         lrclk_sync <= {lrclk_sync[0], lrclk_i};
         sdata_sync <= {sdata_sync[0], sdata_i};
      end
   end

   // Registered rise detect; lr/sd are captured in the same cycle so the event
   // and its sampled data stay aligned.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bclk_d   <= 1'b0;
         rise_evt <= 1'b0;
         lr_smp   <= 1'b0;
         sd_smp   <= 1'b0;
      end else begin
         bclk_d   <= bclk_sync[1];
         rise_evt <= bclk_sync[1] & ~bclk_d;
         lr_smp   <= lrclk_sync[1];
         sd_smp   <= sdata_sync[1];
      end
   end

   assign boundary  = rise_evt && (lr_smp != lr_prev);
   assign full_slot = (bit_cnt >= CW'(DATA_WIDTH));
   assign overrun   = rise_evt && !boundary && (bit_cnt == CW'(SLOT_WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lr_prev <= 1'b0;
      end else if (rise_evt) begin
         lr_prev <= lr_smp;
      end
   end

   // Slot bit counter and shift register; bits past DATA_WIDTH are padding.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else if (!enable) begin
         bit_cnt   <= '0;
         shift_reg <= '0;
      end else if (rise_evt) begin
         if (boundary) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
         end else begin
            if (bit_cnt < CW'(DATA_WIDTH)) begin
               shift_reg <= {shift_reg[DATA_WIDTH-2:0], sd_smp};
            end
            if (bit_cnt != CW'(SLOT_WIDTH)) begin
               bit_cnt <= bit_cnt + CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= SYNC;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_nxt = state;
      load_left = 1'b0;
      load_pair = 1'b0;
      err_set   = 1'b0;
      if (!enable) begin
         state_nxt = SYNC;
      end else begin
         case (state)
            SYNC: begin
               if (boundary && !lr_smp) begin
                  state_nxt = LEFT;
               end
            end
            LEFT: begin
               if (boundary) begin
                  if (full_slot) begin
                     load_left = 1'b1;
                     state_nxt = RIGHT;
                  end else begin
                     err_set   = 1'b1;
                     state_nxt = SYNC;
                  end
               end else if (overrun) begin
                  err_set   = 1'b1;
                  state_nxt = SYNC;
               end
            end
            RIGHT: begin
               // This boundary both closes the frame and opens the next left slot.
               if (boundary) begin
                  if (full_slot) begin
                     load_pair = 1'b1;
                     state_nxt = LEFT;
                  end else begin
                     err_set   = 1'b1;
                     state_nxt = SYNC;
                  end
               end else if (overrun) begin
                  err_set   = 1'b1;
                  state_nxt = SYNC;
               end
            end
            default: state_nxt = SYNC;
         endcase
      end
   end

   // Output words move only together with sample_valid so the downstream pulse
   // synchronizer sees stable data for the whole transfer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: data registers are reset too; these are plain flops, not a memory,
         // and the outputs must read zero during reset.
         left_hold    <= '0;
         left_data    <= '0;
         right_data   <= '0;
         sample_valid <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         sample_valid <= load_pair;
         if (load_left) begin
            left_hold <= shift_reg;
         end
         if (load_pair) begin
            left_data  <= left_hold;
            right_data <= shift_reg;
         end
         if (err_set) begin
            frame_err <= 1'b1;
         end else if (err_clear) begin
            frame_err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
`timescale 1ns/1ps
// Randomized bench for i2s_rx_deserializer: drives I2S slots at the pin level and
// compares against a slot-level model of the framing rules.
module tb_i2s_rx_deserializer;

   localparam int DW      = 24;
   localparam int SW      = 32;
   localparam int HALF    = 160;          // BCLK half period, ns
   localparam int BCLK_P  = 2 * HALF;
   localparam int LAT_NEG = 37;           // pin rise -> valid seen at negedge

   localparam int M_SYNC  = 0;
   localparam int M_LEFT  = 1;
   localparam int M_RIGHT = 2;

   logic          clk = 1'b0;
   logic          reset, enable, bclk, lrclk, sdata, err_clear;
   logic [DW-1:0] left_data, right_data;
   logic          sample_valid, frame_err;

   int            checks = 0;
   int            errors = 0;

   // slot-level model
   int            m_state, m_cnt, n_exp;
   logic          m_prev, m_err, m_en;
   logic [DW-1:0] m_word, m_hold;
   logic [2*DW-1:0] exp_q[$];

   // monitor bookkeeping
   int            n_valid = 0;
   longint        vt[0:31];
   longint        t_rise0 = 0;
   logic [2*DW-1:0] last_pair = '0;
   logic          prev_valid = 1'b0;

   logic [DW-1:0] wl[0:2], wr[0:2];
   logic [2*DW-1:0] saved_pair;
   int            saved_n;

   i2s_rx_deserializer #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW)) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .bclk_i       (bclk),
      .lrclk_i      (lrclk),
      .sdata_i      (sdata),
      .err_clear    (err_clear),
      .left_data    (left_data),
      .right_data   (right_data),
      .sample_valid (sample_valid),
      .frame_err    (frame_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One slot of n BCLK periods at the given LRCLK level, applied to the model.
   task automatic model_slot(input logic lr, input int n, input logic [DW-1:0] w);
      if (lr != m_prev) begin
         if (m_en) begin
            if (m_state == M_SYNC) begin
               if (!lr) m_state = M_LEFT;
            end else if (m_cnt < DW) begin
               m_err   = 1'b1;
               m_state = M_SYNC;
            end else if (m_state == M_LEFT) begin
               m_hold  = m_word;
               m_state = M_RIGHT;
            end else begin
               exp_q.push_back({m_hold, m_word});
               n_exp++;
               m_state = M_LEFT;
            end
         end
         m_prev = lr;
         m_cnt  = n - 1;
         m_word = w;
      end else begin
         m_cnt = m_cnt + n;
      end
      if (!m_en) begin
         m_state = M_SYNC;
      end else if (m_state != M_SYNC && m_cnt >= SW) begin
         m_err   = 1'b1;
         m_state = M_SYNC;
      end
   endtask

   // Codec side: LRCLK/SDATA change on BCLK fall; period 0 carries the previous
   // slot's tail bit, periods 1..DW the word MSB first, the rest random padding.
   task automatic send_slot(input logic lr, input int n, input logic [DW-1:0] w,
                            input int clr_at = -1);
      model_slot(lr, n, w);
      for (int k = 0; k < n; k++) begin
         bclk  = 1'b0;
         lrclk = lr;
         if (k >= 1 && k <= DW) sdata = w[DW-k];
         else                   sdata = 1'($urandom_range(0, 1));
         #(HALF);
         bclk = 1'b1;
         if (k == 0) t_rise0 = $time;
         if (k == clr_at) begin
            fork
               begin
                  repeat (3) @(posedge clk);
                  #1 err_clear = 1'b1;
                  @(posedge clk);
                  #1 err_clear = 1'b0;
               end
            join_none
         end
         #(HALF);
      end
   endtask

   task automatic pulse_clear();
      err_clear = 1'b1;
      #10;
      err_clear = 1'b0;
      m_err = 1'b0;
      #10;
   endtask

   function automatic logic [DW-1:0] rnd_word();
      return DW'($urandom);
   endfunction

   always @(negedge clk) begin
      if (reset) begin
         last_pair  = '0;
         prev_valid = 1'b0;
      end else begin
         if (sample_valid) begin
            check("valid_width", prev_valid, 1'b0);
            check("valid_latency", $time - t_rise0, LAT_NEG);
            if (n_valid < 32) vt[n_valid] = $time;
            n_valid++;
            check("valid_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check("pair", {left_data, right_data}, exp_q.pop_front());
            last_pair = {left_data, right_data};
         end else begin
            check("hold", {left_data, right_data}, last_pair);
         end
         prev_valid = sample_valid;
      end
   end

   initial begin
      reset = 1'b1; enable = 1'b0; bclk = 1'b0; lrclk = 1'b0; sdata = 1'b0; err_clear = 1'b0;
      m_state = M_SYNC; m_cnt = 0; n_exp = 0; m_prev = 1'b0; m_err = 1'b0; m_en = 1'b0;
      m_word = '0; m_hold = '0;
      #43;
      check("rst_left", left_data, 0);
      check("rst_right", right_data, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_err", frame_err, 0);
      reset = 1'b0;
      #20;
      enable = 1'b1; m_en = 1'b1;

      // basic frame after a partial one
      send_slot(1'b1, 32, rnd_word());
      send_slot(1'b0, 32, 24'hA5C3F1);
      send_slot(1'b1, 32, 24'h0F1E2D);
      check("t1_no_early_valid", n_valid, 0);

      // three back-to-back frames
      for (int i = 0; i < 3; i++) begin
         wl[i] = rnd_word();
         wr[i] = rnd_word();
         send_slot(1'b0, 32, wl[i]);
         if (i == 0) begin
            check("t1_left", left_data, 24'hA5C3F1);
            check("t1_right", right_data, 24'h0F1E2D);
         end
         send_slot(1'b1, 32, wr[i]);
      end
      send_slot(1'b0, 32, rnd_word());
      check("t2_count", n_valid, 4);
      for (int i = 1; i < 4; i++) check("t2_spacing", vt[i] - vt[i-1], 64 * BCLK_P);
      check("t2_left", left_data, wl[2]);
      check("t2_right", right_data, wr[2]);

      // short left slot
      send_slot(1'b1, 32, rnd_word());
      send_slot(1'b0, 20, rnd_word());
      saved_n = n_valid;
      send_slot(1'b1, 32, rnd_word());
      check("t3_err", frame_err, m_err);
      send_slot(1'b0, 32, rnd_word());
      send_slot(1'b1, 32, rnd_word());
      send_slot(1'b0, 32, rnd_word());
      check("t3_recover", n_valid, saved_n + 1);
      pulse_clear();
      check("t3_cleared", frame_err, 0);

      // overrun, clear, overrun coinciding with clear
      send_slot(1'b1, 32, rnd_word());
      send_slot(1'b0, 40, rnd_word());
      check("t4_overrun", frame_err, m_err);
      pulse_clear();
      check("t4_cleared", frame_err, 0);
      send_slot(1'b1, 32, rnd_word());
      send_slot(1'b0, 40, rnd_word(), SW);
      check("t4_err_wins", frame_err, 1);
      pulse_clear();
      check("t4_cleared2", frame_err, 0);

      // enable dropped mid right slot
      send_slot(1'b1, 32, rnd_word());
      send_slot(1'b0, 32, rnd_word());
      send_slot(1'b1, 32, rnd_word());
      send_slot(1'b0, 32, rnd_word());
      send_slot(1'b1, 12, rnd_word());
      saved_pair = {left_data, right_data};
      saved_n    = n_valid;
      enable = 1'b0; m_en = 1'b0; m_state = M_SYNC;
      send_slot(1'b1, 20, rnd_word());
      send_slot(1'b0, 32, rnd_word());
      check("t5_no_valid", n_valid, saved_n);
      check("t5_hold", {left_data, right_data}, saved_pair);
      enable = 1'b1; m_en = 1'b1;
      send_slot(1'b1, 32, rnd_word());
      send_slot(1'b0, 32, rnd_word());
      send_slot(1'b1, 32, rnd_word());
      send_slot(1'b0, 32, rnd_word());
      check("t5_resume", n_valid, saved_n + 1);
      check("t5_err_untouched", frame_err, 0);

      // reset mid-frame
      send_slot(1'b1, 32, rnd_word());
      send_slot(1'b0, 32, rnd_word());
      reset = 1'b1;
      #1;
      check("t6_left0", left_data, 0);
      check("t6_right0", right_data, 0);
      check("t6_valid0", sample_valid, 0);
      check("t6_err0", frame_err, 0);
      m_state = M_SYNC; m_prev = 1'b0; m_cnt = 0; m_err = 1'b0;
      #29;
      reset = 1'b0;
      saved_n = n_valid;
      send_slot(1'b1, 32, rnd_word());
      send_slot(1'b0, 32, rnd_word());
      send_slot(1'b1, 32, rnd_word());
      check("t6_no_early", n_valid, saved_n);
      send_slot(1'b0, 32, rnd_word());
      check("t6_first", n_valid, saved_n + 1);

      #1000;
      check("queue_empty", exp_q.size(), 0);
      check("valid_total", n_valid, n_exp);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
